generic_fifo_rd_stream: RTL and testbench

- Read-side engine for the single-clock generic FIFO envelopes built on 1r1w compiled RAMs, e.g. the a20/d1024 envelope.
- Issues `rd_op` pops against the FIFO's `empty` flag and absorbs the RAM read latency in a small output buffer.
- Presents the words downstream as a valid/ready stream with full throughput and no data loss under backpressure.
- Adds enable, flush and sticky error/status for the consumer side.

---
 rtl/generic_fifo_rd_pkg.sv | 21 ++
 rtl/generic_fifo_rd_obuf.sv | 83 ++++++++
 rtl/generic_fifo_rd_stream.sv | 150 +++++++++++++++
 tb/tb_generic_fifo_rd_stream.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/generic_fifo_rd_pkg.sv
// Shared types and default sizing for the generic FIFO read-stream engine.
// The parameter defaults match the a20/d1024 envelope with a single-cycle RAM read.
package generic_fifo_rd_pkg;

    localparam int unsigned DefDatWidth   = 20;
    localparam int unsigned DefRdLat      = 1;
    localparam int unsigned DefObufDepth  = 2;
    localparam int unsigned DefCntWidth   = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } rd_state_e;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/generic_fifo_rd_obuf.sv
// Small synchronous output buffer that absorbs the RAM returns.
// The head entry is read straight from the storage registers, so it is stable until popped.
module generic_fifo_rd_obuf
    import generic_fifo_rd_pkg::*;
#(
    parameter int unsigned DatWidth = DefDatWidth,
    parameter int unsigned Depth    = DefObufDepth,
    localparam int unsigned CntW    = cnt_bits(Depth),
    localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                push_i,
    input  logic [DatWidth-1:0] push_data_i,
    input  logic                pop_i,
    output logic [CntW-1:0]     cnt_o,
    output logic [DatWidth-1:0] head_o,
    output logic                ovf_o
);

    logic [DatWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                full;
    logic                do_push;
    logic                do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        full     = (cnt_q == CntW'(Depth));
        do_pop   = pop_i && (cnt_q != '0);
        // A push into a full buffer is fine when the head leaves on the same edge.
        do_push  = push_i && (!full || do_pop);
        ovf_o    = push_i && full && !do_pop && !clr_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push && !clr_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/generic_fifo_rd_stream.sv
// Read-side engine for the generic single-clock FIFO: pops against `empty`, tracks RAM
// returns in flight and presents the words as a valid/ready stream with flush and status.
module generic_fifo_rd_stream
    import generic_fifo_rd_pkg::*;
#(
    parameter int unsigned DAT_WIDTH  = DefDatWidth,
    parameter int unsigned RD_LAT     = DefRdLat,
    parameter int unsigned OBUF_DEPTH = DefObufDepth,
    parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_op,
    input  logic [DAT_WIDTH-1:0] fifo_rd_data,
    input  logic                 fifo_rd_empty_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DAT_WIDTH-1:0] m_data,
    output logic                 flush_busy,
    output logic                 rd_err,
    output logic [CNT_WIDTH-1:0] pop_cnt
);

    localparam int unsigned IfW    = cnt_bits(RD_LAT);
    localparam int unsigned ObCntW = cnt_bits(OBUF_DEPTH);
    localparam int unsigned OccW   = cnt_bits(RD_LAT + OBUF_DEPTH);

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("generic_fifo_rd_stream: RD_LAT must be 1..3");
    end
    if (OBUF_DEPTH < RD_LAT + 1) begin : g_bad_obuf_depth
        $error("generic_fifo_rd_stream: OBUF_DEPTH must be at least RD_LAT+1");
    end

    rd_state_e            state_q, state_d;
    logic                 flush_busy_q;
    logic [RD_LAT-1:0]    vld_q, vld_d;
    logic [RD_LAT:0]      vld_ext;
    logic [IfW-1:0]       inflight;
    logic [ObCntW-1:0]    obuf_cnt;
    logic [OccW-1:0]      occ;
    logic                 xfer;
    logic                 ret_vld;
    logic                 capture;
    logic                 obuf_clr;
    logic                 obuf_ovf;
    logic                 rd_err_q;
    logic [CNT_WIDTH-1:0] pop_cnt_q;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IfW'(vld_q[i]);
        end
    end

    assign m_valid = (obuf_cnt != '0);
    assign xfer    = m_valid && m_ready;

    // Credit check counts the word leaving this cycle, so m_ready feeds the pop directly.
    assign occ        = OccW'(inflight) + OccW'(obuf_cnt) - OccW'(xfer);
    assign fifo_rd_op = (state_q == StRun) && en && !fifo_empty && !flush
                        && (occ < OccW'(OBUF_DEPTH));

    assign vld_ext  = {vld_q, fifo_rd_op};
    assign vld_d    = vld_ext[RD_LAT-1:0];
    assign ret_vld  = vld_q[RD_LAT-1];
    assign obuf_clr = flush && (state_q != StFlush);
    assign capture  = ret_vld && (state_q != StFlush) && !obuf_clr;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    state_d = StFlush;
                end else if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StFlush;
                end else if (!en && (inflight == '0)) begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (inflight == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            flush_busy_q <= 1'b0;
            vld_q        <= '0;
        end else begin
            state_q      <= state_d;
            flush_busy_q <= (state_d == StFlush);
            vld_q        <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_err_q  <= 1'b0;
            pop_cnt_q <= '0;
        end else begin
            rd_err_q <= rd_err_q || fifo_rd_empty_err || obuf_ovf;
            if (xfer) begin
                pop_cnt_q <= pop_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // The pop credit makes a full-buffer capture unreachable; catch it loudly if it happens.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!obuf_ovf);
        end
    end

    generic_fifo_rd_obuf #(
        .DatWidth (DAT_WIDTH),
        .Depth    (OBUF_DEPTH)
    ) u_obuf (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (obuf_clr),
        .push_i      (capture),
        .push_data_i (fifo_rd_data),
        .pop_i       (xfer),
        .cnt_o       (obuf_cnt),
        .head_o      (m_data),
        .ovf_o       (obuf_ovf)
    );

    assign flush_busy = flush_busy_q;
    assign rd_err     = rd_err_q;
    assign pop_cnt    = pop_cnt_q;

endmodule

// File: tb/tb_generic_fifo_rd_stream.sv
// Self-checking bench: a queue model of the FIFO envelope plus a scoreboard of popped words.
// Every delivered word must be the oldest popped, undiscarded one, in FIFO order.
module tb_generic_fifo_rd_stream;

    localparam int unsigned DW    = 20;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset, en, flush, fifo_empty, fifo_rd_op, fifo_rd_empty_err;
    logic          m_valid, m_ready, flush_busy, rd_err;
    logic [DW-1:0] fifo_rd_data, m_data;
    logic [CW-1:0] pop_cnt;

    int checks = 0;
    int errors = 0;
    int xfer_tot = 0;

    logic [DW-1:0] fifo_q[$];  // words still stored in the FIFO envelope
    logic [DW-1:0] exp_q[$];   // popped, not yet delivered or discarded
    logic [DW-1:0] dlv_q[$];   // log of delivered words
    logic [CW-1:0] model_cnt = '0;
    logic          s_rd_op, s_m_valid, s_flush_busy;
    logic [DW-1:0] s_m_data;

    always #5 clk = ~clk;

    generic_fifo_rd_stream dut (
        .clk               (clk),
        .reset             (reset),
        .en                (en),
        .flush             (flush),
        .fifo_empty        (fifo_empty),
        .fifo_rd_op        (fifo_rd_op),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_rd_empty_err (fifo_rd_empty_err),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .flush_busy        (flush_busy),
        .rd_err            (rd_err),
        .pop_cnt           (pop_cnt)
    );

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample mid-cycle, score, then model the envelope just after the edge.
    task automatic cycle();
        logic [DW-1:0] w;
        logic          popped;
        popped = 1'b0;
        w      = '0;
        @(negedge clk);
        s_rd_op      = fifo_rd_op;
        s_m_valid    = m_valid;
        s_m_data     = m_data;
        s_flush_busy = flush_busy;
        checks++;
        if (pop_cnt !== model_cnt) begin
            errors++;
            $display("FAIL pop_cnt: got %0d want %0d", pop_cnt, model_cnt);
        end
        checks++;
        if (s_rd_op === 1'b1 && fifo_q.size() == 0) begin
            errors++;
            $display("FAIL rd_op_on_empty: got rd_op=1 want 0");
        end
        if (s_m_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL valid_without_word: got m_data=%05h want no valid", s_m_data);
            end else if (s_m_data !== exp_q[0]) begin
                errors++;
                $display("FAIL head_data: got %05h want %05h", s_m_data, exp_q[0]);
            end
            if (m_ready === 1'b1) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                dlv_q.push_back(s_m_data);
                model_cnt = model_cnt + 1'b1;
                xfer_tot++;
            end
        end
        if (s_rd_op === 1'b1 && fifo_q.size() > 0) begin
            w      = fifo_q.pop_front();
            popped = 1'b1;
            exp_q.push_back(w);
        end
        if (flush === 1'b1) exp_q.delete();
        if (reset === 1'b1) begin
            exp_q.delete();
            model_cnt = '0;
        end
        checks++;
        if (exp_q.size() > DEPTH) begin
            errors++;
            $display("FAIL outstanding: got %0d want <= %0d", exp_q.size(), DEPTH);
        end
        @(posedge clk);
        #1;
        if (popped) fifo_rd_data = w;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic settle();
        en      = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 300 && (fifo_q.size() > 0 || exp_q.size() > 0); i++) cycle();
        checks++;
        if (fifo_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL settle: got fifo=%0d outstanding=%0d want 0/0", fifo_q.size(),
                     exp_q.size());
        end
        en = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
        fifo_rd_empty_err = 1'b0; fifo_rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks += 6;
        if (fifo_rd_op !== 1'b0) begin errors++; $display("FAIL rst_rd_op: got %b want 0", fifo_rd_op); end
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        if (m_data !== '0) begin errors++; $display("FAIL rst_m_data: got %05h want 0", m_data); end
        if (flush_busy !== 1'b0) begin errors++; $display("FAIL rst_flush_busy: got %b want 0", flush_busy); end
        if (rd_err !== 1'b0) begin errors++; $display("FAIL rst_rd_err: got %b want 0", rd_err); end
        if (pop_cnt !== '0) begin errors++; $display("FAIL rst_pop_cnt: got %0d want 0", pop_cnt); end
    endtask

    task automatic test_single();
        int op_c, v_c, ops;
        logic [DW-1:0] vd;
        op_c = -1; v_c = -1; ops = 0; vd = '0;
        push_word(20'h12345);
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_rd_op === 1'b1) begin
                ops++;
                if (op_c < 0) op_c = i;
            end
            if (s_m_valid === 1'b1 && v_c < 0) begin
                v_c = i;
                vd  = s_m_data;
            end
        end
        checks += 4;
        if (ops != 1) begin errors++; $display("FAIL single_ops: got %0d want 1", ops); end
        if (op_c < 0 || v_c - op_c != 2) begin
            errors++; $display("FAIL single_latency: got %0d want 2", v_c - op_c);
        end
        if (vd !== 20'h12345) begin errors++; $display("FAIL single_data: got %05h want 12345", vd); end
        if (pop_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", pop_cnt); end
        settle();
    endtask

    task automatic test_back_to_back();
        int fo, lo, no, fv, lv, nv;
        logic [CW-1:0] c0;
        fo = -1; lo = -1; no = 0; fv = -1; lv = -1; nv = 0;
        c0 = model_cnt;
        dlv_q.delete();
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_rd_op === 1'b1) begin no++; if (fo < 0) fo = i; lo = i; end
            if (s_m_valid === 1'b1) begin nv++; if (fv < 0) fv = i; lv = i; end
        end
        checks += 3;
        if (no != 8 || lo - fo != 7) begin
            errors++; $display("FAIL b2b_pops: got %0d over %0d cycles want 8 over 8", no, lo - fo + 1);
        end
        if (nv != 8 || lv - fv != 7) begin
            errors++; $display("FAIL b2b_valid: got %0d over %0d cycles want 8 over 8", nv, lv - fv + 1);
        end
        if (pop_cnt !== c0 + 16'd8) begin
            errors++; $display("FAIL b2b_cnt: got %0d want %0d", pop_cnt, c0 + 16'd8);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= dlv_q.size() || dlv_q[i] !== DW'(i + 1)) begin
                errors++; $display("FAIL b2b_order[%0d]: got %05h want %05h", i,
                                   (i < dlv_q.size()) ? dlv_q[i] : '0, DW'(i + 1));
            end
        end
        settle();
    endtask

    task automatic test_backpressure();
        int ops, nv;
        ops = 0; nv = 0;
        dlv_q.delete();
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        en = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_rd_op === 1'b1) ops++;
            if (s_m_valid === 1'b1) begin
                nv++;
                checks++;
                if (s_m_data !== 20'h00001) begin
                    errors++; $display("FAIL bp_hold: got %05h want 00001", s_m_data);
                end
            end
        end
        checks += 2;
        if (ops != 2) begin errors++; $display("FAIL bp_pops: got %0d want 2", ops); end
        if (nv != 7) begin errors++; $display("FAIL bp_valid_cycles: got %0d want 7", nv); end
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) cycle();
        checks++;
        if (dlv_q.size() != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", dlv_q.size()); end
        for (int i = 0; i < 8 && i < dlv_q.size(); i++) begin
            checks++;
            if (dlv_q[i] !== DW'(i + 1)) begin
                errors++; $display("FAIL bp_order[%0d]: got %05h want %05h", i, dlv_q[i], DW'(i + 1));
            end
        end
        settle();
    endtask

    task automatic test_flush();
        dlv_q.delete();
        for (int i = 1; i <= 8; i++) push_word(DW'(32'h100 + i));
        en = 1'b1; m_ready = 1'b0;
        repeat (3) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        checks += 2;
        if (s_m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", s_m_valid); end
        if (s_flush_busy !== 1'b1) begin errors++; $display("FAIL flush_busy_on: got %b want 1", s_flush_busy); end
        cycle();
        checks++;
        if (s_flush_busy !== 1'b0) begin errors++; $display("FAIL flush_busy_off: got %b want 0", s_flush_busy); end
        m_ready = 1'b1;
        for (int i = 0; i < 20 && dlv_q.size() == 0; i++) cycle();
        checks++;
        if (dlv_q.size() == 0 || dlv_q[0] !== 20'h00103) begin
            errors++; $display("FAIL flush_resume: got %05h want 00103",
                               (dlv_q.size() > 0) ? dlv_q[0] : '0);
        end
        settle();
        checks++;
        if (dlv_q.size() != 6) begin errors++; $display("FAIL flush_total: got %0d want 6", dlv_q.size()); end
    endtask

    task automatic test_err();
        checks++;
        if (rd_err !== 1'b0) begin errors++; $display("FAIL err_pre: got %b want 0", rd_err); end
        fifo_rd_empty_err = 1'b1;
        cycle();
        fifo_rd_empty_err = 1'b0;
        checks++;
        if (rd_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", rd_err); end
        repeat (6) cycle();
        checks++;
        if (rd_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", rd_err); end
    endtask

    task automatic test_reset_mid();
        int nv;
        nv = 0;
        for (int i = 1; i <= 4; i++) push_word(DW'(32'h200 + i));
        en = 1'b1; m_ready = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0; en = 1'b0; m_ready = 1'b1;
        checks += 6;
        if (fifo_rd_op !== 1'b0) begin errors++; $display("FAIL mid_rd_op: got %b want 0", fifo_rd_op); end
        if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
        if (m_data !== '0) begin errors++; $display("FAIL mid_m_data: got %05h want 0", m_data); end
        if (flush_busy !== 1'b0) begin errors++; $display("FAIL mid_flush_busy: got %b want 0", flush_busy); end
        if (rd_err !== 1'b0) begin errors++; $display("FAIL mid_rd_err: got %b want 0", rd_err); end
        if (pop_cnt !== '0) begin errors++; $display("FAIL mid_pop_cnt: got %0d want 0", pop_cnt); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (s_m_valid === 1'b1) nv++;
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL mid_stale_word: got %0d valid cycles want 0", nv); end
        settle();
    endtask

    task automatic test_wrap();
        int start;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        start = xfer_tot;
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 70000 && xfer_tot - start < 65535; i++) begin
            while (fifo_q.size() < 4) push_word(DW'($urandom));
            cycle();
        end
        m_ready = 1'b0;
        checks++;
        if (pop_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_full: got %0d want 65535", pop_cnt); end
        m_ready = 1'b1;
        for (int i = 0; i < 10 && xfer_tot - start < 65536; i++) cycle();
        m_ready = 1'b0;
        checks++;
        if (pop_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %0d want 0", pop_cnt); end
        settle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) < 4 && fifo_q.size() < 16) push_word(DW'($urandom));
            cycle();
        end
        flush = 1'b0;
        settle();
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rand_drain: got m_valid=%b want 0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_err();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
